seq_det_ctrl: RTL and testbench

- Programmable serial-pattern detection controller; generalises the team's fixed-pattern Mealy detectors into one run-time configurable engine.
- Holds the pattern, length, overlap mode and target count, and sequences arm/run/done.
- Counts detections and stops after the target is reached.
- Sits between a bit-serial input stream and a host/control FSM that configures it and starts runs.

---
 rtl/seq_det_ctrl.sv | 108 ++++++++++
 tb/tb_seq_det_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-time programmable serial pattern detector with arm/run/done sequencing
// and a target detection count that ends each run.
module seq_det_ctrl #(
   parameter  int MAXLEN = 8,
   parameter  int CNTW   = 8,
   localparam int LW     = $clog2(MAXLEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [LW-1:0]     cfg_len,
   input  logic              cfg_overlap,
   input  logic [CNTW-1:0]   cfg_target,
   input  logic              start,
   input  logic              abort,
   input  logic              x,
   input  logic              x_valid,
   output logic              z,
   output logic              busy,
   output logic              done,
   output logic [CNTW-1:0]   det_count,
   output logic              cfg_err
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t            state_q, state_d;
   logic [MAXLEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_nx, mask;
   logic [LW-1:0]     len_q, len_d, fill_q, fill_d, fill_sat, eff_len;
   logic [LW:0]       fill1;
   logic [CNTW-1:0]   tgt_q, tgt_d, cnt_q, cnt_d, cnt_inc, eff_tgt;
   logic              ovl_q, ovl_d, z_q, z_d, err_q, err_d;
   logic              cfg_acc, cfg_ok, full, hit;
   // A start in the same cycle as a config write is judged against the incoming values.
   assign cfg_acc  = cfg_we && (state_q != RUN);
   assign eff_len  = cfg_acc ? cfg_len : len_q;
   assign eff_tgt  = cfg_acc ? cfg_target : tgt_q;
   assign cfg_ok   = (eff_len != '0) && (eff_len <= LW'(MAXLEN)) && (eff_tgt != '0);
   assign hist_nx  = {hist_q[MAXLEN-2:0], x};
   assign mask     = ~({MAXLEN{1'b1}} << len_q);
   assign fill1    = {1'b0, fill_q} + (LW+1)'(1);
   assign full     = fill1 >= {1'b0, len_q};
   assign fill_sat = full ? len_q : fill1[LW-1:0];
   assign hit      = full && (((hist_nx ^ pat_q) & mask) == '0);
   assign cnt_inc  = cnt_q + CNTW'(1);
   always_comb begin
      state_d = state_q;
      pat_d   = cfg_acc ? cfg_pattern : pat_q;
      len_d   = eff_len;
      ovl_d   = cfg_acc ? cfg_overlap : ovl_q;
      tgt_d   = eff_tgt;
      hist_d  = hist_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      z_d     = 1'b0;
      err_d   = 1'b0;
      if (state_q != RUN) begin
         if (start && cfg_ok) begin
            state_d = RUN;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
         end else if (start) begin
            err_d = 1'b1;
         end
      end else if (abort) begin
         state_d = IDLE;
      end else if (x_valid) begin
         hist_d = hist_nx;
         fill_d = fill_sat;
         if (hit) begin
            z_d     = 1'b1;
            cnt_d   = cnt_inc;
            fill_d  = ovl_q ? fill_sat : '0;
            state_d = (cnt_inc == tgt_q) ? DONE : RUN;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         tgt_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         z_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         tgt_q   <= tgt_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         err_q   <= err_d;
      end
   end
   assign z         = z_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign det_count = cnt_q;
   assign cfg_err   = err_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed and randomized checks of seq_det_ctrl against a bit-queue
// reference model of the detection rules.
module tb_seq_det_ctrl;
   localparam int MAXLEN = 8;
   localparam int CNTW   = 8;
   localparam int LW     = $clog2(MAXLEN + 1);
   logic              clk = 1'b0;
   logic              rst, cfg_we, cfg_overlap, start, abort, x, x_valid;
   logic [MAXLEN-1:0] cfg_pattern;
   logic [LW-1:0]     cfg_len;
   logic [CNTW-1:0]   cfg_target;
   logic              z, busy, done, cfg_err;
   logic [CNTW-1:0]   det_count;
   int                checks = 0;
   int                errors = 0;
   int                m_state, m_len, m_tgt, m_cnt;
   bit                m_ovl, m_z, m_err;
   bit [MAXLEN-1:0]   m_pat;
   bit                win[$];

   seq_det_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .abort(abort),
      .x(x), .x_valid(x_valid), .z(z), .busy(busy), .done(done), .det_count(det_count),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   function automatic logic [CNTW+3:0] obs();
      return {z, busy, done, cfg_err, det_count};
   endfunction

   function automatic logic [CNTW+3:0] exp_v();
      return {m_z, (m_state == 1), (m_state == 2), m_err, CNTW'(m_cnt)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      cfg_we = 0; start = 0; abort = 0; x = 0; x_valid = 0;
   endtask

   task automatic model_reset();
      m_state = 0; m_len = 0; m_tgt = 0; m_cnt = 0; m_pat = '0; m_ovl = 0;
      m_z = 0; m_err = 0; win.delete();
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1;
      step();
      rst = 0;
      model_reset();
   endtask

   // One cycle of config write and/or start; model applies the same acceptance rules.
   task automatic ctl(input bit we, input bit [MAXLEN-1:0] pat, input int len, input bit ovl,
                      input int tgt, input bit st);
      idle_in();
      cfg_we = we; cfg_pattern = pat; cfg_len = LW'(len); cfg_overlap = ovl;
      cfg_target = CNTW'(tgt); start = st;
      m_z = 0; m_err = 0;
      if (m_state != 1) begin
         if (we) begin m_pat = pat; m_len = len; m_ovl = ovl; m_tgt = tgt; end
         if (st) begin
            if (m_len >= 1 && m_len <= MAXLEN && m_tgt != 0) begin
               m_state = 1; m_cnt = 0; win.delete();
            end else m_err = 1;
         end
      end
      step();
      idle_in();
   endtask

   // One data cycle; a match is the last len received bits equalling the pattern.
   task automatic cycle(input bit b, input bit v, input bit ab);
      bit hit;
      idle_in();
      x = b; x_valid = v; abort = ab;
      m_z = 0; m_err = 0;
      if (m_state == 1) begin
         if (ab) m_state = 0;
         else if (v) begin
            win.push_back(b);
            hit = (win.size() >= m_len);
            for (int i = 0; i < m_len && hit; i++)
               if (win[win.size() - m_len + i] != m_pat[m_len-1-i]) hit = 0;
            if (hit) begin
               m_z = 1;
               m_cnt++;
               if (!m_ovl) win.delete();
               if (m_cnt == m_tgt) m_state = 2;
            end
         end
      end
      step();
      idle_in();
   endtask

   task automatic test_reset();
      idle_in();
      cfg_we = 1; start = 1; cfg_len = 3; cfg_target = 1; cfg_pattern = 8'h05; x_valid = 1; x = 1;
      rst = 1;
      step();
      rst = 0;
      model_reset();
      idle_in();
      checks++;
      if (obs() !== '0) begin
         errors++; $display("FAIL reset_outputs got=%h exp=0", obs());
      end
      step();
      checks++;
      if (obs() !== '0) begin
         errors++; $display("FAIL reset_hold got=%h exp=0", obs());
      end
   endtask

   task automatic test_cfg_err();
      do_reset();
      ctl(0, '0, 0, 0, 0, 1);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL cfg_err_unconfigured got err=%b busy=%b exp err=1 busy=0", cfg_err, busy);
      end
      cycle(0, 0, 0);
      checks++;
      if (obs() !== exp_v() || cfg_err !== 1'b0) begin
         errors++; $display("FAIL cfg_err_one_cycle got=%h exp=%h", obs(), exp_v());
      end
      ctl(1, 8'h05, 0, 0, 3, 1);
      checks++;
      if (cfg_err !== 1'b1 || obs() !== exp_v()) begin
         errors++; $display("FAIL cfg_err_len0 got=%h exp=%h", obs(), exp_v());
      end
      ctl(1, 8'h05, 3, 0, 0, 1);
      checks++;
      if (cfg_err !== 1'b1 || obs() !== exp_v()) begin
         errors++; $display("FAIL cfg_err_tgt0 got=%h exp=%h", obs(), exp_v());
      end
      ctl(1, 8'h05, MAXLEN + 1, 0, 1, 1);
      checks++;
      if (cfg_err !== 1'b1 || obs() !== exp_v()) begin
         errors++; $display("FAIL cfg_err_len_big got=%h exp=%h", obs(), exp_v());
      end
   endtask

   task automatic test_basic();
      bit [11:0] bits = 12'b101011_101011;
      int zc = 0;
      do_reset();
      ctl(1, 8'b101011, 6, 0, 2, 1);
      checks++;
      if (busy !== 1'b1 || cfg_err !== 1'b0) begin
         errors++; $display("FAIL basic_start got busy=%b err=%b exp busy=1 err=0", busy, cfg_err);
      end
      for (int i = 11; i >= 0; i--) begin
         cycle(bits[i], 1, 0);
         zc += z;
         checks++;
         if (obs() !== exp_v()) begin
            errors++; $display("FAIL basic_bit%0d got=%h exp=%h", 11 - i, obs(), exp_v());
         end
      end
      checks++;
      if (zc !== 2 || det_count !== 8'd2 || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_final got z=%0d cnt=%0d done=%b busy=%b exp z=2 cnt=2 done=1 busy=0",
                  zc, det_count, done, busy);
      end
      for (int i = 11; i >= 0; i--) cycle(bits[i], 1, 0);
      checks++;
      if (det_count !== 8'd2 || done !== 1'b1 || z !== 1'b0) begin
         errors++; $display("FAIL basic_done_hold got cnt=%0d done=%b z=%b exp cnt=2 done=1 z=0", det_count, done, z);
      end
   endtask

   task automatic test_overlap();
      bit [4:0] bits = 5'b10101;
      for (int o = 0; o <= 1; o++) begin
         int zc = 0;
         ctl(1, 8'b101, 3, o[0], 8, 1);
         for (int i = 4; i >= 0; i--) begin
            cycle(bits[i], 1, 0);
            zc += z;
            checks++;
            if (obs() !== exp_v()) begin
               errors++; $display("FAIL overlap%0d_bit%0d got=%h exp=%h", o, 4 - i, obs(), exp_v());
            end
         end
         checks++;
         if (zc !== (o ? 2 : 1) || det_count !== CNTW'(o ? 2 : 1)) begin
            errors++; $display("FAIL overlap%0d_count got z=%0d cnt=%0d exp=%0d", o, zc, det_count, o ? 2 : 1);
         end
         cycle(0, 0, 1);
      end
   endtask

   task automatic test_gaps();
      bit [11:0] bits = 12'b101011_101011;
      int zc = 0;
      ctl(1, 8'b101011, 6, 0, 2, 1);
      for (int i = 11; i >= 0; i--) begin
         cycle(bits[i], 1, 0);
         zc += z;
         checks++;
         if (obs() !== exp_v()) begin
            errors++; $display("FAIL gaps_bit%0d got=%h exp=%h", 11 - i, obs(), exp_v());
         end
         for (int g = 0; g < 3; g++) begin
            cycle(~bits[i], 0, 0);
            zc += z;
            checks++;
            if (obs() !== exp_v()) begin
               errors++; $display("FAIL gaps_idle%0d_%0d got=%h exp=%h", 11 - i, g, obs(), exp_v());
            end
         end
      end
      checks++;
      if (zc !== 2 || done !== 1'b1) begin
         errors++; $display("FAIL gaps_total got z=%0d done=%b exp z=2 done=1", zc, done);
      end
   endtask

   task automatic test_abort();
      bit [5:0] bits = 6'b101011;
      ctl(1, 8'b101011, 6, 0, 2, 1);
      for (int i = 5; i >= 1; i--) cycle(bits[i], 1, 0);
      cycle(bits[0], 1, 1);
      checks++;
      if (z !== 1'b0 || det_count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL abort_match got z=%b cnt=%0d busy=%b done=%b exp all 0", z, det_count, busy, done);
      end
      ctl(0, '0, 0, 0, 0, 1);
      for (int i = 5; i >= 0; i--) cycle(bits[i], 1, 0);
      checks++;
      if (z !== 1'b1 || det_count !== 8'd1 || busy !== 1'b1 || obs() !== exp_v()) begin
         errors++; $display("FAIL abort_restart got=%h exp z=1 cnt=1 busy=1", obs());
      end
      cycle(0, 0, 1);
      checks++;
      if (det_count !== 8'd1 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_keep_count got cnt=%0d busy=%b exp cnt=1 busy=0", det_count, busy);
      end
   endtask

   task automatic test_rst_mid();
      bit [5:0] bits = 6'b101011;
      ctl(1, 8'b101011, 6, 0, 2, 1);
      for (int i = 5; i >= 2; i--) cycle(bits[i], 1, 0);
      ctl(1, 8'b111111, 6, 1, 1, 1);
      for (int i = 1; i >= 0; i--) cycle(bits[i], 1, 0);
      checks++;
      if (z !== 1'b1 || det_count !== 8'd1 || busy !== 1'b1) begin
         errors++; $display("FAIL run_cfg_ignored got z=%b cnt=%0d busy=%b exp z=1 cnt=1 busy=1", z, det_count, busy);
      end
      for (int i = 5; i >= 2; i--) cycle(bits[i], 1, 0);
      idle_in();
      x_valid = 1; x = 1;
      rst = 1;
      step();
      rst = 0;
      model_reset();
      idle_in();
      checks++;
      if (obs() !== '0) begin
         errors++; $display("FAIL rst_mid_outputs got=%h exp=0", obs());
      end
      ctl(0, '0, 0, 0, 0, 1);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL rst_mid_cfg_cleared got err=%b busy=%b exp err=1 busy=0", cfg_err, busy);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int r = 0; r < 40; r++) begin
         int len = $urandom_range(1, MAXLEN);
         bit [MAXLEN-1:0] pat = MAXLEN'($urandom);
         ctl(1, pat, len, 1'($urandom_range(0, 1)), $urandom_range(1, 4), 1);
         checks++;
         if (obs() !== exp_v()) begin
            errors++; $display("FAIL rand_start%0d got=%h exp=%h", r, obs(), exp_v());
         end
         for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 2) == 0) begin
               for (int i = len - 1; i >= 0; i--) begin
                  cycle(pat[i], 1, 0);
                  checks++;
                  if (obs() !== exp_v()) begin
                     errors++; $display("FAIL rand_pat%0d_%0d got=%h exp=%h", r, c, obs(), exp_v());
                  end
               end
            end else begin
               cycle(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
               checks++;
               if (obs() !== exp_v()) begin
                  errors++; $display("FAIL rand_bit%0d_%0d got=%h exp=%h", r, c, obs(), exp_v());
               end
            end
         end
         if ($urandom_range(0, 1) == 1) cycle(0, 0, 1);
      end
   endtask

   initial begin
      idle_in();
      rst = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_target = '0;
      model_reset();
      test_reset();
      test_cfg_err();
      test_basic();
      test_overlap();
      test_gaps();
      test_abort();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
